// File: rtl/q3_mux_arbiter_if.sv
// Request/ack and output-bus bundle between two sources and q3_mux_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface q3_mux_arbiter_if #(
    parameter int DATA_W = 7
);
    logic              en;
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              ack_a;
    logic              ack_b;
    logic [DATA_W:0]   out_data;
    logic              out_valid;
    logic              out_src;
    logic              busy;

    modport master (
        output en, req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, out_data, out_valid, out_src, busy
    );

    modport slave (
        input  en, req_a, data_a, req_b, data_b,
        output ack_a, ack_b, out_data, out_valid, out_src, busy
    );
endinterface

// File: rtl/q3_mux_arbiter.sv
// Two-source req/ack arbiter loading a registered {1,payload} output; Q3_ARB_FIXED_PRIO_EN makes A win ties.
// Latency: one edge from req to out_valid/ack; grants spaced 2+HOLD_CYCLES cycles apart.
// Backpressure: requests seen only in IDLE; req must stay high until ack, later reqs wait for the next IDLE.
module q3_mux_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int DATA_W      = 7
) (
    input logic             clk,
    input logic             rst_n,
    q3_mux_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t          state, state_nxt;
    logic [7:0]      hold_cnt, hold_cnt_nxt;
    logic            last_grant, last_grant_nxt;   // 1 = B
    logic [DATA_W:0] out_data_q, out_data_nxt;
    logic            out_src_q, out_src_nxt;
    logic            out_valid_q, out_valid_nxt;
    logic            ack_a_q, ack_a_nxt;
    logic            ack_b_q, ack_b_nxt;
    logic            busy_q, busy_nxt;
    logic            win_b;

    always_comb begin
        win_b = 1'b0;
        if (bus.req_a && bus.req_b) begin
`ifdef Q3_ARB_FIXED_PRIO_EN
            win_b = 1'b0;
`else
            win_b = ~last_grant;
`endif
        end else begin
            win_b = bus.req_b;
        end
    end

    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        last_grant_nxt = last_grant;
        out_data_nxt   = out_data_q;
        out_src_nxt    = out_src_q;
        out_valid_nxt  = 1'b0;
        ack_a_nxt      = 1'b0;
        ack_b_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && (bus.req_a || bus.req_b)) begin
                    out_data_nxt   = {1'b1, (win_b ? bus.data_b : bus.data_a)};
                    out_src_nxt    = win_b;
                    last_grant_nxt = win_b;
                    out_valid_nxt  = 1'b1;
                    ack_a_nxt      = ~win_b;
                    ack_b_nxt      = win_b;
                    state_nxt      = ACK;
                end
            end
            ACK: begin
                if (HOLD_CYCLES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HOLD_INIT;
                end
            end
            HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= 8'd0;
            last_grant  <= 1'b1;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            last_grant  <= last_grant_nxt;
            out_data_q  <= out_data_nxt;
            out_src_q   <= out_src_nxt;
            out_valid_q <= out_valid_nxt;
            ack_a_q     <= ack_a_nxt;
            ack_b_q     <= ack_b_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ack_a     = ack_a_q;
    assign bus.ack_b     = ack_b_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_q3_mux_arbiter.sv
// Bench for q3_mux_arbiter: directed scenarios plus random req/ack traffic against a grant-timing model.
module tb_q3_mux_arbiter;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q3_mux_arbiter_if #(.DATA_W(7)) bus ();
    q3_mux_arbiter_if #(.DATA_W(7)) bus0 ();

    q3_mux_arbiter #(.HOLD_CYCLES(H), .DATA_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    q3_mux_arbiter #(.HOLD_CYCLES(0), .DATA_W(7)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: edges remaining before arbitration may happen again, plus last winner.
    int       m_gap;
    bit       m_last;
    bit [7:0] m_data;
    bit       m_valid, m_ack_a, m_ack_b, m_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gap = 0; m_last = 1'b1; m_data = 8'h00;
        m_valid = 0; m_ack_a = 0; m_ack_b = 0; m_src = 0;
    endtask

    task automatic model_step();
        bit wb;
        if (m_gap == 0 && bus.en && (bus.req_a || bus.req_b)) begin
            if (bus.req_a && bus.req_b) begin
`ifdef Q3_ARB_FIXED_PRIO_EN
                wb = 1'b0;
`else
                wb = !m_last;
`endif
            end else begin
                wb = bus.req_b;
            end
            m_data  = {1'b1, (wb ? bus.data_b : bus.data_a)};
            m_src   = wb;
            m_last  = wb;
            m_valid = 1; m_ack_a = !wb; m_ack_b = wb;
            m_gap   = 1 + H;
        end else begin
            m_valid = 0; m_ack_a = 0; m_ack_b = 0;
            if (m_gap > 0) m_gap--;
        end
    endtask

    task automatic check_all();
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("ack_a", 32'(bus.ack_a), 32'(m_ack_a));
        chk("ack_b", 32'(bus.ack_b), 32'(m_ack_b));
        chk("out_src", 32'(bus.out_src), 32'(m_src));
        chk("busy", 32'(bus.busy), 32'(m_gap > 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t2_exp [4];
        int grants, last_c, cnt, c;
`ifdef Q3_ARB_FIXED_PRIO_EN
        t2_exp = '{8'h81, 8'h81, 8'h81, 8'h81};
`else
        t2_exp = '{8'h81, 8'hFF, 8'h81, 8'hFF};
`endif
        bus.en = 1; bus.req_a = 0; bus.req_b = 0; bus.data_a = '0; bus.data_b = '0;
        bus0.en = 1; bus0.req_a = 0; bus0.req_b = 0; bus0.data_a = '0; bus0.data_b = '0;
        model_reset();
        #2;
        check_all();
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single A request: one-edge latency, busy for 1+H cycles.
        bus.req_a = 1; bus.data_a = 7'h15;
        cycle();
        chk("t1_out_data", 32'(bus.out_data), 32'h95);
        chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_ack_a", 32'(bus.ack_a), 32'h1);
        chk("t1_out_src", 32'(bus.out_src), 32'h0);
        bus.req_a = 0;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.busy) cnt++; else break;
        end
        chk("t1_busy_cycles", 32'(cnt), 32'(1 + H));

        // Zero-hold instance: B only, regrant two cycles later.
        bus0.req_b = 1; bus0.data_b = 7'h2A;
        cycle();
        chk("t3_out_data", 32'(bus0.out_data), 32'hAA);
        chk("t3_out_valid", 32'(bus0.out_valid), 32'h1);
        chk("t3_ack_b", 32'(bus0.ack_b), 32'h1);
        chk("t3_out_src", 32'(bus0.out_src), 32'h1);
        cycle();
        chk("t3_gap_valid", 32'(bus0.out_valid), 32'h0);
        chk("t3_gap_busy", 32'(bus0.busy), 32'h0);
        cycle();
        chk("t3_regrant_valid", 32'(bus0.out_valid), 32'h1);
        chk("t3_regrant_ack_b", 32'(bus0.ack_b), 32'h1);
        bus0.req_b = 0;
        cycle();
        cycle();

        // Both held high after reset: alternation (or A only) every 2+H cycles.
        do_reset();
        bus.req_a = 1; bus.data_a = 7'h01; bus.req_b = 1; bus.data_b = 7'h7F;
        grants = 0; last_c = 0;
        for (int i = 1; i <= 40 && grants < 4; i++) begin
            cycle();
            if (bus.out_valid) begin
                chk("t2_out_data", 32'(bus.out_data), 32'(t2_exp[grants]));
                if (grants > 0) chk("t2_spacing", 32'(i - last_c), 32'(2 + H));
                last_c = i;
                grants++;
            end
        end
        chk("t2_grants", 32'(grants), 32'd4);
        bus.req_a = 0; bus.req_b = 0;
        for (int i = 0; i < 8; i++) cycle();

        // en low blocks arbitration; raising it grants on the next edge.
        bus.en = 0; bus.req_a = 1; bus.data_a = 7'h55;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_valid", 32'(bus.out_valid), 32'h0);
            chk("t4_ack_a", 32'(bus.ack_a), 32'h0);
            chk("t4_busy", 32'(bus.busy), 32'h0);
        end
        bus.en = 1;
        cycle();
        chk("t4_grant_ack_a", 32'(bus.ack_a), 32'h1);
        chk("t4_grant_data", 32'(bus.out_data), 32'hD5);
        bus.req_a = 0;

        // B raised during A's hold is served on the first IDLE edge.
        cycle();
        bus.req_b = 1; bus.data_b = 7'h33;
        c = 1;
        for (int i = 2; i <= 20; i++) begin
            cycle();
            c = i;
            if (bus.out_valid) break;
        end
        chk("t5_grant_cycle", 32'(c), 32'(2 + H));
        chk("t5_out_src", 32'(bus.out_src), 32'h1);
        chk("t5_out_data", 32'(bus.out_data), 32'hB3);
        chk("t5_ack_b", 32'(bus.ack_b), 32'h1);
        bus.req_b = 0;
        for (int i = 0; i < 8; i++) cycle();

        // Reset in HOLD: outputs clear at once; A wins the tie afterwards.
        bus.req_a = 1; bus.data_a = 7'h0A;
        cycle();
        bus.req_a = 0;
        cycle();
        bus.req_a = 1; bus.data_a = 7'h0C; bus.req_b = 1; bus.data_b = 7'h44;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 32'h0);
        chk("t6_rst_out_data", 32'(bus.out_data), 32'h0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("t6_ack_a", 32'(bus.ack_a), 32'h1);
        chk("t6_out_src", 32'(bus.out_src), 32'h0);
        chk("t6_out_data", 32'(bus.out_data), 32'h8C);
        bus.req_a = 0;

        // Random traffic: requesters hold req until acked, then drop or replace it.
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (m_ack_a) begin
                if ($urandom_range(1, 0) == 0) bus.req_a = 0;
                else bus.data_a = 7'($urandom);
            end else if (!bus.req_a && $urandom_range(99, 0) < 30) begin
                bus.req_a = 1; bus.data_a = 7'($urandom);
            end
            if (m_ack_b) begin
                if ($urandom_range(1, 0) == 0) bus.req_b = 0;
                else bus.data_b = 7'($urandom);
            end else if (!bus.req_b && $urandom_range(99, 0) < 30) begin
                bus.req_b = 1; bus.data_b = 7'($urandom);
            end
            bus.en = ($urandom_range(99, 0) < 85);
            if ($urandom_range(399, 0) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/q3_mux_arbiter.md
Name: q3_mux_arbiter

Overview:
- Two-requester arbiter and sequencer for the 7-bit registered output mux.
- Replaces the static select bit with per-source req/ack handshakes.
- Grants one source at a time and loads its 7-bit payload into the output register, with bit 7 forced to 1.
- Enforces a programmable hold (dwell) time before the next grant.

Parameters:
- HOLD_CYCLES, 4: idle dwell cycles after each transfer before re-arbitration; legal range 0..255.
- DATA_W, 7: payload width; the output is DATA_W+1 bits.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; sampled only in IDLE.
- req_a  input  1  source A request; held high until ack_a is seen.
- data_a  input  DATA_W  source A payload; stable while req_a is high.
- req_b  input  1  source B request.
- data_b  input  DATA_W  source B payload.
- ack_a  output  1  one-cycle acknowledge to A.
- ack_b  output  1  one-cycle acknowledge to B.
- out_data  output  DATA_W+1  registered mux output; bit DATA_W is fixed 1 after the first transfer.
- out_valid  output  1  one-cycle strobe when out_data is updated.
- out_src  output  1  0 = last transfer from A, 1 = from B.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - out_data = 0, out_valid = 0, ack_a = 0, ack_b = 0, out_src = 0, busy = 0.
  - state = IDLE, hold counter = 0.
  - last_grant = B, so A wins the first tie.
- Reset is asynchronous and may arrive mid-operation. It aborts any state; no ack is issued for the interrupted request, and the requester must re-present it.
- FSM states: IDLE, ACK, HOLD.
- IDLE:
  - If en=1 and any req is high, the winner is chosen combinationally.
  - At the next edge: out_data <= {1'b1, data_winner}; out_src <= winner; last_grant <= winner; out_valid <= 1; ack_winner <= 1; state <= ACK.
  - If en=0 or no req: state stays IDLE and outputs hold their values. out_valid and ack stay 0.
- ACK (exactly one cycle):
  - out_valid and ack are high during this cycle.
  - The requester samples ack at the edge leaving ACK and drops or replaces req on that same edge.
  - Next state is HOLD with counter = HOLD_CYCLES-1, or IDLE directly if HOLD_CYCLES = 0.
  - out_valid and ack return to 0.
- HOLD:
  - Counter decrements each cycle; at 0 the next state is IDLE.
  - Requests are ignored and out_data is held.
- Arbitration, round robin by default:
  - Single requester: that requester wins.
  - Both requesting: the source opposite last_grant wins.
- Latency:
  - Minimum request-to-out_valid latency is 1 edge.
  - Back-to-back grant spacing is 2+HOLD_CYCLES cycles.
- Boundary rules:
  - A req raised during ACK or HOLD is not lost; it is served in the next IDLE.
  - en falling during ACK or HOLD does not abort the transfer.
  - A req dropped before ack is a protocol violation; the bench does not drive it and behaviour is unspecified.
  - data_x is sampled only on the IDLE→ACK edge.

Optional Feature:
- Macro: Q3_ARB_FIXED_PRIO_EN.
- Defined: A always wins when both requesters are active. last_grant is still updated but ignored, and B can starve.
- Undefined: round-robin arbitration as above.

Test Plan:
- Reset, then req_a=1, data_a=7'h15 → 1 cycle later: out_data=8'h95, out_valid=1, ack_a=1, out_src=0. busy stays high for 1+HOLD_CYCLES cycles (5 with default).
- req_a and req_b held high continuously, data_a=7'h01, data_b=7'h7F, HOLD_CYCLES=4 → grants alternate A,B,A,B (out_data 81,FF,81,FF) every 6 cycles. With Q3_ARB_FIXED_PRIO_EN, all four grants go to A.
- HOLD_CYCLES=0, req_b only, data_b=7'h2A → out_data=8'hAA; next grant possible 2 cycles after the first.
- en=0 with req_a=1 for 10 cycles → no ack, out_valid=0, busy=0. Raising en gives a grant on the next edge.
- req_b raised during HOLD of an A transfer → B is granted on the first IDLE cycle after HOLD expires, with no lost request.
- rst_n asserted during HOLD → all outputs 0 immediately and asynchronously. After release, a pending req_a is granted, with A winning a tie.
